// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline blocks.
// Holds the MEM-stage access sequencer state encoding and the common datapath widths.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } mem_state_e;

  // The pipeline is frozen while a request is pending, while one is being launched, or after a hang.
  function automatic logic mem_stalls(input mem_state_e state, input logic access);
    return ((state == ST_IDLE) && access) || (state == ST_ACCESS) || (state == ST_ERR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
// The active-low clear is asynchronous.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency req/ack data memory: freezes the front of
// the pipeline during an access, hands captured load data to MEM/WB for one advancing cycle.
module mem_access_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadMEM,
  input  logic              MemWriteMEM,
  input  logic [DATA_W-1:0] AddressMEM,
  input  logic [DATA_W-1:0] WriteDataMEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ReadDataMEM,
  output logic              StallMEM,
  output logic              BubbleWB,
  output logic              err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic              access;

  assign access = MemReadMEM | MemWriteMEM;

  // NOTE: every register here is a plain flop, so all of them take a reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // NOTE: each signal gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          addr_d   = AddressMEM;
          wdata_d  = WriteDataMEM;
          we_d     = MemWriteMEM;
          req_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // An ack arriving on the last allowed cycle still completes the access.
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (to_cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign StallMEM    = mem_stalls(state_q, access);
  assign BubbleWB    = StallMEM;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign ReadDataMEM = rdata_q;
  assign err         = err_q;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (StallMEM),
    .cnt_o (stall_cnt)
  );

endmodule
